// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory/writeback with
// req/ack memory handshakes and timeout detection. Optional MCU_PERF_EN builds the retired counter.
module mc_control_unit #(
   parameter int OPCODE_W  = 4,
   parameter int ALUCTRL_W = 3,
   parameter int WAIT_W    = 4,
   parameter int MAX_WAIT  = 15,
   parameter int RET_W     = 16
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [OPCODE_W-1:0]  i_opcode,
   input  logic                 i_zero,
   input  logic                 i_imem_ack,
   input  logic                 i_dmem_ack,
   output logic                 o_imem_req,
   output logic                 o_dmem_req,
   output logic                 o_ir_we,
   output logic                 o_pc_we,
   output logic [1:0]           o_pcsrc,
   output logic                 o_wmem,
   output logic                 o_m2reg,
   output logic [ALUCTRL_W-1:0] o_aluctrl,
   output logic                 o_alusrc,
   output logic                 o_wreg,
   output logic                 o_jal,
   output logic [2:0]           o_state,
   output logic                 o_illegal_op,
   output logic                 o_timeout_err,
   output logic [RET_W-1:0]     o_retired
);

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

   state_t                r_state;
   state_t                w_next;
   logic [OPCODE_W-1:0]   r_op;
   logic [WAIT_W-1:0]     r_wait;
   logic                  r_timeoutErr;

   logic [3:0]            w_op4;
   logic                  w_illegal;
   logic                  w_isLoad;
   logic                  w_isStore;
   logic                  w_waitExpired;
   logic [ALUCTRL_W-1:0]  w_opAluCtrl;
   logic                  w_opAluSrc;

   // Any set bit above the 4-bit opcode field marks the instruction illegal.
   assign w_op4         = r_op[3:0];
   assign w_illegal     = (r_op >> 4) != '0;
   assign w_isLoad      = !w_illegal && (w_op4[3:1] == 3'b010);
   assign w_isStore     = !w_illegal && (w_op4[3:1] == 3'b011);
   assign w_waitExpired = (MAX_WAIT != 0) && (r_wait == MAX_WAIT_C);

   // ALU controls shared by EXEC, MEM and WB so they stay stable across the instruction.
   assign w_opAluCtrl = w_isStore ? '0 :
                        w_isLoad  ? ALUCTRL_W'(1) :
                                    ALUCTRL_W'({1'b0, w_op4[1:0]} + 3'd1);
   assign w_opAluSrc  = w_isLoad || (w_op4[3] && w_op4[2]);

   always_comb begin
      w_next       = r_state;
      o_imem_req   = 1'b0;
      o_dmem_req   = 1'b0;
      o_ir_we      = 1'b0;
      o_pc_we      = 1'b0;
      o_pcsrc      = 2'd0;
      o_wmem       = 1'b0;
      o_m2reg      = 1'b0;
      o_aluctrl    = '0;
      o_alusrc     = 1'b0;
      o_wreg       = 1'b0;
      o_jal        = 1'b0;
      o_illegal_op = 1'b0;
      case (r_state)
         S_BOOT:   w_next = S_FETCH;
         S_FETCH: begin
            o_imem_req = 1'b1;
            if (i_imem_ack) begin
               o_ir_we = 1'b1;
               w_next  = S_DECODE;
            end else if (w_waitExpired) begin
               w_next = S_ERR;
            end
         end
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            if (w_illegal) begin
               o_illegal_op = 1'b1;
               o_pc_we      = 1'b1;
               w_next       = S_FETCH;
            end else begin
               case (w_op4)
                  4'b0000, 4'b0001: begin
                     o_pc_we = 1'b1;
                     o_pcsrc = w_op4[0] ? 2'd2 : 2'd1;
                     o_wreg  = 1'b1;
                     w_next  = S_FETCH;
                  end
                  4'b0010, 4'b0011: begin
                     o_aluctrl = ALUCTRL_W'(w_op4[0] ? 3'd6 : 3'd5);
                     o_pc_we   = 1'b1;
                     o_pcsrc   = i_zero ? 2'd1 : 2'd0;
                     w_next    = S_FETCH;
                  end
                  4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                     o_aluctrl = w_opAluCtrl;
                     o_alusrc  = w_opAluSrc;
                     w_next    = S_MEM;
                  end
                  default: begin
                     o_aluctrl = w_opAluCtrl;
                     o_alusrc  = w_opAluSrc;
                     w_next    = S_WB;
                  end
               endcase
            end
         end
         S_MEM: begin
            o_dmem_req = 1'b1;
            o_aluctrl  = w_opAluCtrl;
            o_alusrc   = w_opAluSrc;
            o_wmem     = w_isStore;
            if (i_dmem_ack) begin
               if (w_isStore) begin
                  o_pc_we = 1'b1;
                  w_next  = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end else if (w_waitExpired) begin
               w_next = S_ERR;
            end
         end
         S_WB: begin
            o_wreg    = 1'b1;
            o_jal     = 1'b1;
            o_m2reg   = w_isLoad;
            o_pc_we   = 1'b1;
            o_aluctrl = w_opAluCtrl;
            o_alusrc  = w_opAluSrc;
            w_next    = S_FETCH;
         end
         S_ERR:    w_next = S_ERR;
         default:  w_next = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_BOOT;
         r_op         <= '0;
         r_timeoutErr <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE)
            r_op <= i_opcode;
         if (r_state != S_ERR && w_next == S_ERR)
            r_timeoutErr <= 1'b1;
      end
   end

   // Wait counter restarts on each state change and only counts unacknowledged memory cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait <= '0;
      end else if (w_next != r_state) begin
         r_wait <= '0;
      end else if (((r_state == S_FETCH) && !i_imem_ack) ||
                   ((r_state == S_MEM) && !i_dmem_ack)) begin
         if (r_wait != WAIT_SAT)
            r_wait <= r_wait + WAIT_W'(1);
      end
   end

`ifdef MCU_PERF_EN
   logic [RET_W-1:0] r_retired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_retired <= '0;
      else if (o_pc_we)
         r_retired <= r_retired + RET_W'(1);
   end

   assign o_retired = r_retired;
`else
   assign o_retired = '0;
`endif

   assign o_state       = r_state;
   assign o_timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: per-cycle stimulus and expected strobes are queued,
// then replayed and compared each cycle. Built with OPCODE_W=6 and MAX_WAIT=8.
module tb_mc_control_unit;

   localparam int RET_W = 16;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        zero;
   logic        imemAck;
   logic        dmemAck;
   logic        imemReq;
   logic        dmemReq;
   logic        irWe;
   logic        pcWe;
   logic [1:0]  pcsrc;
   logic        wmem;
   logic        m2reg;
   logic [2:0]  aluctrl;
   logic        alusrc;
   logic        wreg;
   logic        jal;
   logic [2:0]  state;
   logic        illegalOp;
   logic        timeoutErr;
   logic [RET_W-1:0] retired;
   logic [18:0] obsVec;

   int checks = 0;
   int errors = 0;
   int expRetired = 0;

   typedef struct packed {
      logic       ia;
      logic       da;
      logic       z;
      logic [5:0] op;
   } stim_t;

   stim_t       stimQ[$];
   logic [18:0] expQ[$];

   mc_control_unit #(
      .OPCODE_W(6), .ALUCTRL_W(3), .WAIT_W(4), .MAX_WAIT(8), .RET_W(RET_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_zero(zero),
      .i_imem_ack(imemAck), .i_dmem_ack(dmemAck),
      .o_imem_req(imemReq), .o_dmem_req(dmemReq), .o_ir_we(irWe), .o_pc_we(pcWe),
      .o_pcsrc(pcsrc), .o_wmem(wmem), .o_m2reg(m2reg), .o_aluctrl(aluctrl),
      .o_alusrc(alusrc), .o_wreg(wreg), .o_jal(jal), .o_state(state),
      .o_illegal_op(illegalOp), .o_timeout_err(timeoutErr), .o_retired(retired)
   );

   assign obsVec = {state, imemReq, dmemReq, irWe, pcWe, pcsrc, wmem, m2reg,
                    aluctrl, alusrc, wreg, jal, illegalOp, timeoutErr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected strobe vector in obsVec field order.
   function automatic logic [18:0] ev(input logic [2:0] st, input logic ireq, input logic dreq,
                                      input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                      input logic wm, input logic m2r, input logic [2:0] alu,
                                      input logic asrc, input logic wr, input logic jl,
                                      input logic ill, input logic tmo);
      return {st, ireq, dreq, irwe, pcwe, pcs, wm, m2r, alu, asrc, wr, jl, ill, tmo};
   endfunction

   function automatic logic [RET_W-1:0] expRet();
`ifdef MCU_PERF_EN
      return RET_W'(expRetired);
`else
      return '0;
`endif
   endfunction

   task automatic pushCycle(input logic ia, input logic da, input logic z,
                            input logic [5:0] op, input logic [18:0] e);
      stim_t s;
      s.ia = ia; s.da = da; s.z = z; s.op = op;
      stimQ.push_back(s);
      expQ.push_back(e);
      if (e[12]) expRetired++;
   endtask

   task automatic pushFetchDecode(input logic [5:0] op);
      pushCycle(1'b1, 1'b0, 1'b0, op, ev(3'd1,1,0,1,0,2'd0,0,0,3'd0,0,0,0,0,0));
      pushCycle(1'b0, 1'b0, 1'b0, op, ev(3'd2,0,0,0,0,2'd0,0,0,3'd0,0,0,0,0,0));
   endtask

   task automatic pushAluInstr(input logic [5:0] op, input logic [2:0] alu, input logic asrc);
      pushFetchDecode(op);
      pushCycle(1'b0, 1'b0, 1'b0, op, ev(3'd3,0,0,0,0,2'd0,0,0,alu,asrc,0,0,0,0));
      pushCycle(1'b0, 1'b0, 1'b0, op, ev(3'd5,0,0,0,1,2'd0,0,0,alu,asrc,1,1,0,0));
   endtask

   task automatic applyStimulus(input stim_t s);
      imemAck = s.ia;
      dmemAck = s.da;
      zero    = s.z;
      opcode  = s.op;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      imemAck = 1'b0; dmemAck = 1'b0; zero = 1'b0; opcode = '0;
      @(negedge clk);
      rst_n = 1'b1;
      expRetired = 0;
      stimQ.delete();
      expQ.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      imemAck = 1'b0; dmemAck = 1'b0; zero = 1'b0; opcode = '0;
      repeat (2) @(negedge clk);
      #2;
      checks++;
      if (obsVec !== 19'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", obsVec, 19'd0);
      end
      checks++;
      if (retired !== '0) begin
         errors++;
         $display("[TB] FAIL reset_retired: got %0d expected 0", retired);
      end
      @(negedge clk);
      rst_n = 1'b1;
      expRetired = 0;
      #2;
      checks++;
      if (obsVec !== ev(3'd0,0,0,0,0,2'd0,0,0,3'd0,0,0,0,0,0)) begin
         errors++;
         $display("[TB] FAIL reset_boot: got %h expected %h", obsVec, 19'd0);
      end
   endtask

   task automatic test_add();
      stim_t s; logic [18:0] e; int cyc = 0;
      pushAluInstr(6'b001000, 3'd1, 1'b0);
      while (expQ.size() != 0) begin
         @(negedge clk);
         s = stimQ.pop_front(); e = expQ.pop_front();
         applyStimulus(s); #2; cyc++; checks++;
         if (obsVec !== e) begin
            errors++;
            $display("[TB] FAIL add cyc%0d: got %h expected %h", cyc, obsVec, e);
         end
      end
      @(posedge clk); #1; checks++;
      if (retired !== expRet()) begin
         errors++;
         $display("[TB] FAIL add_retired: got %0d expected %0d", retired, expRet());
      end
   endtask

   task automatic test_back_to_back();
      stim_t s; logic [18:0] e; int cyc = 0;
      pushAluInstr(6'b001110, 3'd3, 1'b1);
      pushAluInstr(6'b001011, 3'd4, 1'b0);
      pushAluInstr(6'b001101, 3'd2, 1'b1);
      while (expQ.size() != 0) begin
         @(negedge clk);
         s = stimQ.pop_front(); e = expQ.pop_front();
         applyStimulus(s); #2; cyc++; checks++;
         if (obsVec !== e) begin
            errors++;
            $display("[TB] FAIL back_to_back cyc%0d: got %h expected %h", cyc, obsVec, e);
         end
      end
      @(posedge clk); #1; checks++;
      if (retired !== expRet()) begin
         errors++;
         $display("[TB] FAIL back_to_back_retired: got %0d expected %0d", retired, expRet());
      end
   endtask

   task automatic test_branch();
      stim_t s; logic [18:0] e; int cyc = 0;
      pushFetchDecode(6'b000010);
      pushCycle(0, 0, 1, 6'b000010, ev(3'd3,0,0,0,1,2'd1,0,0,3'd5,0,0,0,0,0));
      pushFetchDecode(6'b000010);
      pushCycle(0, 0, 0, 6'b000010, ev(3'd3,0,0,0,1,2'd0,0,0,3'd5,0,0,0,0,0));
      pushFetchDecode(6'b000011);
      pushCycle(0, 0, 1, 6'b000011, ev(3'd3,0,0,0,1,2'd1,0,0,3'd6,0,0,0,0,0));
      pushFetchDecode(6'b000011);
      pushCycle(0, 0, 0, 6'b000011, ev(3'd3,0,0,0,1,2'd0,0,0,3'd6,0,0,0,0,0));
      pushFetchDecode(6'b000000);
      pushCycle(0, 0, 1, 6'b000000, ev(3'd3,0,0,0,1,2'd1,0,0,3'd0,0,1,0,0,0));
      pushFetchDecode(6'b000001);
      pushCycle(0, 0, 0, 6'b000001, ev(3'd3,0,0,0,1,2'd2,0,0,3'd0,0,1,0,0,0));
      while (expQ.size() != 0) begin
         @(negedge clk);
         s = stimQ.pop_front(); e = expQ.pop_front();
         applyStimulus(s); #2; cyc++; checks++;
         if (obsVec !== e) begin
            errors++;
            $display("[TB] FAIL branch cyc%0d: got %h expected %h", cyc, obsVec, e);
         end
      end
      @(posedge clk); #1; checks++;
      if (retired !== expRet()) begin
         errors++;
         $display("[TB] FAIL branch_retired: got %0d expected %0d", retired, expRet());
      end
   endtask

   task automatic test_load();
      stim_t s; logic [18:0] e; int cyc = 0;
      pushFetchDecode(6'b000101);
      pushCycle(0, 0, 0, 6'b000101, ev(3'd3,0,0,0,0,2'd0,0,0,3'd1,1,0,0,0,0));
      for (int i = 0; i < 3; i++)
         pushCycle(0, 0, 0, 6'b000101, ev(3'd4,0,1,0,0,2'd0,0,0,3'd1,1,0,0,0,0));
      pushCycle(0, 1, 0, 6'b000101, ev(3'd4,0,1,0,0,2'd0,0,0,3'd1,1,0,0,0,0));
      pushCycle(0, 0, 0, 6'b000101, ev(3'd5,0,0,0,1,2'd0,0,1,3'd1,1,1,1,0,0));
      pushFetchDecode(6'b000100);
      pushCycle(0, 0, 0, 6'b000100, ev(3'd3,0,0,0,0,2'd0,0,0,3'd1,1,0,0,0,0));
      pushCycle(0, 1, 0, 6'b000100, ev(3'd4,0,1,0,0,2'd0,0,0,3'd1,1,0,0,0,0));
      pushCycle(0, 0, 0, 6'b000100, ev(3'd5,0,0,0,1,2'd0,0,1,3'd1,1,1,1,0,0));
      while (expQ.size() != 0) begin
         @(negedge clk);
         s = stimQ.pop_front(); e = expQ.pop_front();
         applyStimulus(s); #2; cyc++; checks++;
         if (obsVec !== e) begin
            errors++;
            $display("[TB] FAIL load cyc%0d: got %h expected %h", cyc, obsVec, e);
         end
      end
      @(posedge clk); #1; checks++;
      if (retired !== expRet()) begin
         errors++;
         $display("[TB] FAIL load_retired: got %0d expected %0d", retired, expRet());
      end
   endtask

   task automatic test_store();
      stim_t s; logic [18:0] e; int cyc = 0;
      pushFetchDecode(6'b000111);
      pushCycle(0, 0, 0, 6'b000111, ev(3'd3,0,0,0,0,2'd0,0,0,3'd0,0,0,0,0,0));
      pushCycle(0, 1, 0, 6'b000111, ev(3'd4,0,1,0,1,2'd0,1,0,3'd0,0,0,0,0,0));
      pushFetchDecode(6'b000110);
      pushCycle(0, 0, 0, 6'b000110, ev(3'd3,0,0,0,0,2'd0,0,0,3'd0,0,0,0,0,0));
      pushCycle(0, 0, 0, 6'b000110, ev(3'd4,0,1,0,0,2'd0,1,0,3'd0,0,0,0,0,0));
      pushCycle(0, 1, 0, 6'b000110, ev(3'd4,0,1,0,1,2'd0,1,0,3'd0,0,0,0,0,0));
      while (expQ.size() != 0) begin
         @(negedge clk);
         s = stimQ.pop_front(); e = expQ.pop_front();
         applyStimulus(s); #2; cyc++; checks++;
         if (obsVec !== e) begin
            errors++;
            $display("[TB] FAIL store cyc%0d: got %h expected %h", cyc, obsVec, e);
         end
      end
      @(posedge clk); #1; checks++;
      if (retired !== expRet()) begin
         errors++;
         $display("[TB] FAIL store_retired: got %0d expected %0d", retired, expRet());
      end
   endtask

   task automatic test_illegal();
      stim_t s; logic [18:0] e; int cyc = 0;
      pushFetchDecode(6'b010000);
      pushCycle(0, 0, 0, 6'b010000, ev(3'd3,0,0,0,1,2'd0,0,0,3'd0,0,0,0,1,0));
      pushFetchDecode(6'b100101);
      pushCycle(0, 1, 0, 6'b100101, ev(3'd3,0,0,0,1,2'd0,0,0,3'd0,0,0,0,1,0));
      pushCycle(0, 0, 0, 6'b000000, ev(3'd1,1,0,0,0,2'd0,0,0,3'd0,0,0,0,0,0));
      while (expQ.size() != 0) begin
         @(negedge clk);
         s = stimQ.pop_front(); e = expQ.pop_front();
         applyStimulus(s); #2; cyc++; checks++;
         if (obsVec !== e) begin
            errors++;
            $display("[TB] FAIL illegal cyc%0d: got %h expected %h", cyc, obsVec, e);
         end
      end
      @(posedge clk); #1; checks++;
      if (retired !== expRet()) begin
         errors++;
         $display("[TB] FAIL illegal_retired: got %0d expected %0d", retired, expRet());
      end
   endtask

   task automatic test_reset_mid();
      stim_t s; logic [18:0] e; int cyc = 0;
      doReset();
      pushFetchDecode(6'b000111);
      pushCycle(0, 0, 0, 6'b000111, ev(3'd3,0,0,0,0,2'd0,0,0,3'd0,0,0,0,0,0));
      pushCycle(0, 0, 0, 6'b000111, ev(3'd4,0,1,0,0,2'd0,1,0,3'd0,0,0,0,0,0));
      pushCycle(0, 0, 0, 6'b000111, ev(3'd4,0,1,0,0,2'd0,1,0,3'd0,0,0,0,0,0));
      while (expQ.size() != 0) begin
         @(negedge clk);
         s = stimQ.pop_front(); e = expQ.pop_front();
         applyStimulus(s); #2; cyc++; checks++;
         if (obsVec !== e) begin
            errors++;
            $display("[TB] FAIL reset_mid cyc%0d: got %h expected %h", cyc, obsVec, e);
         end
      end
      #1 rst_n = 1'b0;
      #1; checks++;
      if (obsVec !== 19'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_abort: got %h expected %h", obsVec, 19'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      expRetired = 0;
      #2; checks++;
      if (obsVec !== 19'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_boot: got %h expected %h", obsVec, 19'd0);
      end
      @(negedge clk);
      #2; checks++;
      if (obsVec !== ev(3'd1,1,0,0,0,2'd0,0,0,3'd0,0,0,0,0,0)) begin
         errors++;
         $display("[TB] FAIL reset_mid_fetch: got %h expected %h", obsVec,
                  ev(3'd1,1,0,0,0,2'd0,0,0,3'd0,0,0,0,0,0));
      end
   endtask

   task automatic test_timeout();
      stim_t s; logic [18:0] e; int cyc = 0;
      doReset();
      for (int i = 0; i < 9; i++)
         pushCycle(0, 0, 0, 6'b001000, ev(3'd1,1,0,0,0,2'd0,0,0,3'd0,0,0,0,0,0));
      for (int i = 0; i < 3; i++)
         pushCycle(1, 1, 0, 6'b001000, ev(3'd6,0,0,0,0,2'd0,0,0,3'd0,0,0,0,0,1));
      while (expQ.size() != 0) begin
         @(negedge clk);
         s = stimQ.pop_front(); e = expQ.pop_front();
         applyStimulus(s); #2; cyc++; checks++;
         if (obsVec !== e) begin
            errors++;
            $display("[TB] FAIL imem_timeout cyc%0d: got %h expected %h", cyc, obsVec, e);
         end
      end
      doReset();
      #2; checks++;
      if (obsVec !== 19'd0) begin
         errors++;
         $display("[TB] FAIL timeout_cleared: got %h expected %h", obsVec, 19'd0);
      end
      cyc = 0;
      pushFetchDecode(6'b000101);
      pushCycle(0, 0, 0, 6'b000101, ev(3'd3,0,0,0,0,2'd0,0,0,3'd1,1,0,0,0,0));
      for (int i = 0; i < 9; i++)
         pushCycle(0, 0, 0, 6'b000101, ev(3'd4,0,1,0,0,2'd0,0,0,3'd1,1,0,0,0,0));
      pushCycle(0, 1, 0, 6'b000101, ev(3'd6,0,0,0,0,2'd0,0,0,3'd0,0,0,0,0,1));
      while (expQ.size() != 0) begin
         @(negedge clk);
         s = stimQ.pop_front(); e = expQ.pop_front();
         applyStimulus(s); #2; cyc++; checks++;
         if (obsVec !== e) begin
            errors++;
            $display("[TB] FAIL dmem_timeout cyc%0d: got %h expected %h", cyc, obsVec, e);
         end
      end
   endtask

   task automatic test_ack_wins();
      stim_t s; logic [18:0] e; int cyc = 0;
      doReset();
      for (int i = 0; i < 8; i++)
         pushCycle(0, 0, 0, 6'b001000, ev(3'd1,1,0,0,0,2'd0,0,0,3'd0,0,0,0,0,0));
      pushAluInstr(6'b001000, 3'd1, 1'b0);
      while (expQ.size() != 0) begin
         @(negedge clk);
         s = stimQ.pop_front(); e = expQ.pop_front();
         applyStimulus(s); #2; cyc++; checks++;
         if (obsVec !== e) begin
            errors++;
            $display("[TB] FAIL ack_wins cyc%0d: got %h expected %h", cyc, obsVec, e);
         end
      end
      @(posedge clk); #1; checks++;
      if (retired !== expRet()) begin
         errors++;
         $display("[TB] FAIL ack_wins_retired: got %0d expected %0d", retired, expRet());
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_branch();
      test_load();
      test_store();
      test_illegal();
      test_reset_mid();
      test_timeout();
      test_ack_wins();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
